// File: rtl/multicore_run_ctrl.sv
// -----------------------------------------------------------------------------
// multicore_run_ctrl
//   Responder side of the start/done run protocol. A one-cycle active-low
//   startN request, accepted only while idle, broadcasts a one-cycle start
//   pulse to every core. Per-core done pulses are then collected into a sticky
//   mask. The run ends when every core has reported done, or when the optional
//   RUN-cycle limit expires first. The controller counts RUN cycles and reports
//   completion and timeout to the host.
//
// Parameters
//   CORE_COUNT      number of cores started and monitored
//   CNT_W           width of cycle_count; the count saturates at all-ones
//   TIMEOUT_CYCLES  RUN-cycle limit before forced completion; 0 disables it
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous reset, active-high
//   startN           in   run request, active-low, level-sampled in IDLE only
//   core_done        in   per-core done pulse or level, bit i = core i
//   core_start       out  per-core start pulse, one cycle, all bits together
//   processor_ready  out  high while idle and able to accept startN
//   processDone      out  high from run completion until the next accepted start
//   timeout          out  high together with processDone when the run timed out
//   cycle_count      out  number of RUN cycles in the last or current run
// -----------------------------------------------------------------------------
module multicore_run_ctrl #(
  parameter int CORE_COUNT     = 8,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startN,
  input  logic [CORE_COUNT-1:0] core_done,
  output logic [CORE_COUNT-1:0] core_start,
  output logic                  processor_ready,
  output logic                  processDone,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  // The limit fires on the edge where the count is one short of the limit,
  // so the count left behind equals TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nx;
  logic [CORE_COUNT-1:0]   done_mask, done_mask_nx;
  logic [CORE_COUNT-1:0]   core_start_nx;
  logic                    ready_nx, done_nx, timeout_nx;
  logic [CNT_W-1:0]        count_nx;

  // Done reports collected so far including this cycle's; a pulse arriving on
  // the very edge that completes the set still counts.
  logic [CORE_COUNT-1:0]   seen;
  logic                    all_done;
  logic                    timeout_hit;

  assign seen        = done_mask | core_done;
  assign all_done    = &seen;
  assign timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);

  // State and every output live in this one register block, so all outputs
  // come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      done_mask       <= '0;
      core_start      <= '0;
      processor_ready <= 1'b0;
      processDone     <= 1'b0;
      timeout         <= 1'b0;
      cycle_count     <= '0;
    end else begin
      state           <= state_nx;
      done_mask       <= done_mask_nx;
      core_start      <= core_start_nx;
      processor_ready <= ready_nx;
      processDone     <= done_nx;
      timeout         <= timeout_nx;
      cycle_count     <= count_nx;
    end
  end

  // Next-state logic. startN is only looked at in IDLE, so requests made
  // during START or RUN are dropped rather than queued.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!startN) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (all_done || timeout_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs. Status outputs hold by default so
  // results of the last run stay visible in IDLE until a new start.
  always_comb begin
    core_start_nx = '0;
    ready_nx      = processor_ready;
    done_nx       = processDone;
    timeout_nx    = timeout;
    count_nx      = cycle_count;
    done_mask_nx  = done_mask;
    unique case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (!startN) begin
          core_start_nx = '1;
          ready_nx      = 1'b0;
          done_nx       = 1'b0;
          timeout_nx    = 1'b0;
          done_mask_nx  = '0;
        end
      end
      START: begin
        // core_done is deliberately not folded into the mask here.
        count_nx = '0;
      end
      RUN: begin
        done_mask_nx = seen;
        count_nx     = (cycle_count == CNT_MAX) ? cycle_count
                                                : cycle_count + CNT_W'(1);
        // Completion takes priority over a timeout on the same edge.
        if (all_done) begin
          ready_nx = 1'b1;
          done_nx  = 1'b1;
        end else if (timeout_hit) begin
          ready_nx   = 1'b1;
          done_nx    = 1'b1;
          timeout_nx = 1'b1;
        end
      end
      default: begin
        core_start_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicore_run_ctrl
//   Self-checking bench for multicore_run_ctrl. Main instance: 8 cores, 32-bit
//   count, 16-cycle timeout. Second instance: 4 cores, 3-bit count, timeout
//   disabled, used for count saturation. Expected results come from a run-level
//   model: given the RUN-cycle index at which each core first reports done,
//   the end cycle, timeout flag and final count follow directly.
// -----------------------------------------------------------------------------
module tb_multicore_run_ctrl;

  localparam int NCORE      = 8;
  localparam int TB_TIMEOUT = 16;
  localparam int NEVER      = 1000;

  typedef int idx_t [NCORE];

  logic             clk = 1'b0;
  logic             rst;
  logic             startN;
  logic [NCORE-1:0] core_done;
  logic [NCORE-1:0] core_start;
  logic             processor_ready;
  logic             processDone;
  logic             timeout;
  logic [31:0]      cycle_count;

  logic             startN_b;
  logic [3:0]       core_done_b;
  logic [3:0]       core_start_b;
  logic             ready_b;
  logic             done_b;
  logic             timeout_b;
  logic [2:0]       count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicore_run_ctrl #(
    .CORE_COUNT(NCORE), .CNT_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .startN(startN), .core_done(core_done),
    .core_start(core_start), .processor_ready(processor_ready),
    .processDone(processDone), .timeout(timeout), .cycle_count(cycle_count)
  );

  multicore_run_ctrl #(
    .CORE_COUNT(4), .CNT_W(3), .TIMEOUT_CYCLES(0)
  ) dut_sat (
    .clk(clk), .rst(rst), .startN(startN_b), .core_done(core_done_b),
    .core_start(core_start_b), .processor_ready(ready_b),
    .processDone(done_b), .timeout(timeout_b), .cycle_count(count_b)
  );

  // Advance one clock; inputs change and outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run-level reference: the run ends on the RUN cycle where the last core
  // first reports done, unless the limit expires first (tie -> completion).
  function automatic void model(input idx_t idx, output int end_i,
                                output bit to, output int cnt);
    int last = 0;
    for (int i = 0; i < NCORE; i++) if (idx[i] > last) last = idx[i];
    if (last >= TB_TIMEOUT) begin
      end_i = TB_TIMEOUT - 1;
      to    = 1'b1;
      cnt   = TB_TIMEOUT;
    end else begin
      end_i = last;
      to    = 1'b0;
      cnt   = last + 1;
    end
  endfunction

  // Request a run from IDLE (or with startN already low) and check the
  // START cycle and the entry into RUN. Done pulses here must be ignored.
  task automatic start_run(input bit hold_low);
    startN    = 1'b0;
    core_done = NCORE'($urandom);
    tick();
    n_checks++;
    if (core_start !== 8'hFF) begin
      n_fail++;
      $display("FAIL start_pulse: core_start=%h expected ff", core_start);
    end
    n_checks++;
    if ({processor_ready, processDone, timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_status: ready/done/timeout=%b expected 000",
               {processor_ready, processDone, timeout});
    end
    startN    = hold_low ? 1'b0 : 1'b1;
    core_done = NCORE'($urandom);
    tick();
    n_checks++;
    if ({core_start, processor_ready, cycle_count} !== {8'h00, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL run_entry: core_start=%h ready=%b count=%0d expected 00/0/0",
               core_start, processor_ready, cycle_count);
    end
  endtask

  // Drive RUN cycles 0..end from per-core first-done indices and check the
  // outcome. Optional noise: repeated done pulses from finished cores and
  // startN requests, both of which must have no effect.
  task automatic run_body(input idx_t idx, input bit dup_noise,
                          input bit startn_noise, input bit hold_low);
    int e, cnt;
    bit to;
    logic [NCORE-1:0] vec;
    model(idx, e, to, cnt);
    for (int j = 0; j <= e; j++) begin
      vec = '0;
      for (int i = 0; i < NCORE; i++) begin
        if (idx[i] == j) vec[i] = 1'b1;
        else if (dup_noise && idx[i] < j && $urandom_range(0, 1) == 1) vec[i] = 1'b1;
      end
      core_done = vec;
      if (hold_low) startN = 1'b0;
      else if (startn_noise) startN = ($urandom_range(0, 1) == 1);
      tick();
      if (j < e) begin
        n_checks++;
        if ({core_start, processor_ready, processDone} !== {8'h00, 2'b00}) begin
          n_fail++;
          $display("FAIL run_busy cycle %0d: core_start=%h ready=%b done=%b expected 00/0/0",
                   j, core_start, processor_ready, processDone);
        end
      end else begin
        n_checks++;
        if ({core_start, processor_ready, processDone, timeout} !== {8'h00, 2'b11, to}) begin
          n_fail++;
          $display("FAIL run_end: core_start=%h ready=%b done=%b timeout=%b expected 00/1/1/%b",
                   core_start, processor_ready, processDone, timeout, to);
        end
        n_checks++;
        if (cycle_count !== 32'(cnt)) begin
          n_fail++;
          $display("FAIL run_count: cycle_count=%0d expected %0d", cycle_count, cnt);
        end
      end
    end
    core_done = '0;
    if (!hold_low) startN = 1'b1;
  endtask

  // Sit in IDLE with stray done pulses; results must hold.
  task automatic idle_hold(input int n, input bit to, input int cnt);
    for (int k = 0; k < n; k++) begin
      startN    = 1'b1;
      core_done = NCORE'($urandom);
      tick();
      n_checks++;
      if ({core_start, processor_ready, processDone, timeout, cycle_count}
          !== {8'h00, 2'b11, to, 32'(cnt)}) begin
        n_fail++;
        $display("FAIL idle_hold: core_start=%h ready=%b done=%b timeout=%b count=%0d expected 00/1/1/%b/%0d",
                 core_start, processor_ready, processDone, timeout, cycle_count, to, cnt);
      end
    end
    core_done = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; startN = 1'b1; core_done = '0;
    startN_b = 1'b1; core_done_b = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({core_start, processor_ready, processDone, timeout, cycle_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: core_start=%h ready=%b done=%b timeout=%b count=%0d expected all 0",
                 core_start, processor_ready, processDone, timeout, cycle_count);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({core_start, processor_ready, processDone, timeout, cycle_count}
        !== {8'h00, 1'b1, 2'b00, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_release: core_start=%h ready=%b done=%b timeout=%b count=%0d expected 00/1/0/0/0",
               core_start, processor_ready, processDone, timeout, cycle_count);
    end
    n_checks++;
    if (ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_sat: ready=%b expected 1", ready_b);
    end
  endtask

  task automatic test_staggered_done();
    idx_t idx;
    for (int i = 0; i < NCORE; i++) idx[i] = 3 + i;
    start_run(1'b0);
    run_body(idx, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cycle_count !== 32'd11) begin
      n_fail++;
      $display("FAIL staggered_count: cycle_count=%0d expected 11", cycle_count);
    end
    idle_hold(2, 1'b0, 11);
  endtask

  task automatic test_all_first_cycle();
    idx_t idx;
    for (int i = 0; i < NCORE; i++) idx[i] = 0;
    start_run(1'b0);
    run_body(idx, 1'b0, 1'b0, 1'b0);
    idle_hold(1, 1'b0, 1);
  endtask

  task automatic test_start_ignored();
    idx_t idx;
    for (int i = 0; i < NCORE; i++) idx[i] = $urandom_range(0, 9);
    start_run(1'b0);
    run_body(idx, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    idx_t idx;
    // startN held low across completion: every IDLE visit retriggers.
    for (int i = 0; i < NCORE; i++) idx[i] = 0;
    start_run(1'b1);
    run_body(idx, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if ({core_start, processDone, processor_ready} !== {8'hFF, 2'b00}) begin
      n_fail++;
      $display("FAIL retrigger: core_start=%h done=%b ready=%b expected ff/0/0",
               core_start, processDone, processor_ready);
    end
    startN = 1'b1;
    tick();
    n_checks++;
    if ({core_start, cycle_count} !== {8'h00, 32'd0}) begin
      n_fail++;
      $display("FAIL retrigger_run: core_start=%h count=%0d expected 00/0",
               core_start, cycle_count);
    end
    for (int i = 0; i < NCORE; i++) idx[i] = $urandom_range(0, 6);
    run_body(idx, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    idx_t idx;
    for (int i = 0; i < NCORE; i++) idx[i] = $urandom_range(0, 12);
    idx[5] = NEVER;
    start_run(1'b0);
    run_body(idx, 1'b1, 1'b0, 1'b0);
    idle_hold(3, 1'b1, 16);
    // Last done exactly on the limit edge: completion wins.
    for (int i = 0; i < NCORE; i++) idx[i] = $urandom_range(0, 12);
    idx[5] = TB_TIMEOUT - 1;
    start_run(1'b0);
    run_body(idx, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({timeout, cycle_count} !== {1'b0, 32'd16}) begin
      n_fail++;
      $display("FAIL timeout_tie: timeout=%b count=%0d expected 0/16", timeout, cycle_count);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run(1'b0);
    for (int j = 0; j < 4; j++) begin
      core_done = NCORE'(1 << j);
      tick();
    end
    rst = 1'b1;
    core_done = '0;
    tick();
    n_checks++;
    if ({core_start, processor_ready, processDone, timeout, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: core_start=%h ready=%b done=%b timeout=%b count=%0d expected all 0",
               core_start, processor_ready, processDone, timeout, cycle_count);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      core_done = '1;
      tick();
      n_checks++;
      if ({core_start, processor_ready, processDone, timeout, cycle_count}
          !== {8'h00, 1'b1, 2'b00, 32'd0}) begin
        n_fail++;
        $display("FAIL midrun_after: core_start=%h ready=%b done=%b timeout=%b count=%0d expected 00/1/0/0/0",
                 core_start, processor_ready, processDone, timeout, cycle_count);
      end
    end
    core_done = '0;
  endtask

  task automatic test_random_runs();
    idx_t idx;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NCORE; i++) idx[i] = $urandom_range(0, 12);
      if ($urandom_range(0, 2) == 0)
        idx[$urandom_range(0, NCORE - 1)] =
          ($urandom_range(0, 1) == 1) ? NEVER : $urandom_range(14, 20);
      start_run(1'b0);
      run_body(idx, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        int e, cnt;
        bit to;
        model(idx, e, to, cnt);
        idle_hold($urandom_range(1, 2), to, cnt);
      end
    end
  endtask

  // Narrow counter with no timeout: long runs saturate and never time out.
  task automatic test_saturation();
    int lens [2] = '{5, 20};
    for (int r = 0; r < 2; r++) begin
      int len = lens[r];
      int exp_cnt = (len > 7) ? 7 : len;
      startN_b = 1'b0;
      tick();
      n_checks++;
      if (core_start_b !== 4'hF) begin
        n_fail++;
        $display("FAIL sat_start: core_start=%h expected f", core_start_b);
      end
      startN_b = 1'b1;
      tick();
      for (int j = 0; j < len; j++) begin
        core_done_b = {(j == len - 1), 3'($urandom)};
        tick();
        if (j == len - 1) begin
          n_checks++;
          if ({done_b, timeout_b, ready_b, count_b} !== {3'b101, 3'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL sat_end len %0d: done=%b timeout=%b ready=%b count=%0d expected 1/0/1/%0d",
                     len, done_b, timeout_b, ready_b, count_b, exp_cnt);
          end
        end else if (j == len - 2) begin
          n_checks++;
          if ({done_b, timeout_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL sat_busy len %0d: done=%b timeout=%b expected 0/0",
                     len, done_b, timeout_b);
          end
        end
      end
      core_done_b = '0;
    end
  endtask

  initial begin
    test_reset();
    test_staggered_done();
    test_all_first_cycle();
    test_start_ignored();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    test_random_runs();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
